// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the memory-request FSM state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned PERF_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    DREQ,
    DONE,
    HALTED
  } req_state_t;

  function automatic logic is_data_req(input logic ren, input logic wen);
    return ren | wen;
  endfunction

endpackage

// File: rtl/mem_request_unit_if.sv
// Pipeline/cache-side signal bundle for mem_request_unit.
// master: the request unit itself; slave: the surrounding pipeline, cache and hazard unit.
interface mem_request_unit_if #(
  parameter int unsigned ADDR_W = 32
);
  import cpu_types_pkg::*;

  logic              mem_dREN;
  logic              mem_dWEN;
  logic              mem_halt;
  logic [ADDR_W-1:0] mem_addr;
  logic [ADDR_W-1:0] mem_store;
  logic              mem_advance;
  logic              mem_flush;
  logic              ihit_raw;
  logic              dhit_raw;

  logic              imemREN;
  logic              dmemREN;
  logic              dmemWEN;
  logic [ADDR_W-1:0] dmemaddr;
  logic [ADDR_W-1:0] dmemstore;
  logic              ihit;
  logic              dhit;
  logic              halt;
  logic              busy;

  logic [PERF_W-1:0] perf_dstall_cnt;
  logic [PERF_W-1:0] perf_dacc_cnt;

  modport master (
    input  mem_dREN, mem_dWEN, mem_halt, mem_addr, mem_store,
           mem_advance, mem_flush, ihit_raw, dhit_raw,
    output imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
           ihit, dhit, halt, busy, perf_dstall_cnt, perf_dacc_cnt
  );

  modport slave (
    output mem_dREN, mem_dWEN, mem_halt, mem_addr, mem_store,
           mem_advance, mem_flush, ihit_raw, dhit_raw,
    input  imemREN, dmemREN, dmemWEN, dmemaddr, dmemstore,
           ihit, dhit, halt, busy, perf_dstall_cnt, perf_dacc_cnt
  );

endinterface

// File: rtl/mem_request_perf.sv
// Saturating data-stall / data-access counter pair; only compiled when MEM_REQUEST_PERF_EN is defined.
`ifdef MEM_REQUEST_PERF_EN
module mem_request_perf
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = PERF_W
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_dreq,
  input  logic             dhit,
  input  logic             halt,
  output logic [CNT_W-1:0] dstall_cnt,
  output logic [CNT_W-1:0] dacc_cnt
);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dstall_cnt <= '0;
      dacc_cnt   <= '0;
    end else if (!halt) begin
      if (in_dreq && (dstall_cnt != '1)) dstall_cnt <= dstall_cnt + 1'b1;
      if (dhit && (dacc_cnt != '1))      dacc_cnt   <= dacc_cnt + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/mem_request_unit.sv
// MEM-stage request framing, qualified cache hits and halt sequencing.
// Optional perf counters: define MEM_REQUEST_PERF_EN.
module mem_request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input logic               CLK,
  input logic               nRST,
  mem_request_unit_if.master bus
);

  req_state_t        state;
  logic              imem_ren_q;
  logic              dmem_ren_q;
  logic              dmem_wen_q;
  logic              halt_q;
  logic              busy_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] store_q;
  logic              dhit_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= IDLE;
      imem_ren_q <= 1'b1;
      dmem_ren_q <= 1'b0;
      dmem_wen_q <= 1'b0;
      halt_q     <= 1'b0;
      busy_q     <= 1'b0;
      addr_q     <= '0;
      store_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A data access outranks a halt in the same instruction slot.
          if (is_data_req(bus.mem_dREN, bus.mem_dWEN) && !bus.mem_flush) begin
            state      <= DREQ;
            dmem_ren_q <= bus.mem_dREN & ~bus.mem_dWEN;
            dmem_wen_q <= bus.mem_dWEN;
            addr_q     <= bus.mem_addr;
            store_q    <= bus.mem_store;
            busy_q     <= 1'b1;
            imem_ren_q <= 1'b0;
          end else if (bus.mem_halt && !bus.mem_flush) begin
            state      <= HALTED;
            halt_q     <= 1'b1;
            imem_ren_q <= 1'b0;
          end
        end
        DREQ: begin
          if (bus.dhit_raw) begin
            dmem_ren_q <= 1'b0;
            dmem_wen_q <= 1'b0;
            busy_q     <= 1'b0;
            imem_ren_q <= 1'b1;
            state      <= bus.mem_advance ? IDLE : DONE;
          end
        end
        DONE: begin
          // Stalled instruction still sits in EX/MEM; wait for it to leave.
          if (bus.mem_advance || bus.mem_flush) state <= IDLE;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dhit_q = bus.dhit_raw & (state == DREQ);

  assign bus.imemREN   = imem_ren_q;
  assign bus.dmemREN   = dmem_ren_q;
  assign bus.dmemWEN   = dmem_wen_q;
  assign bus.dmemaddr  = addr_q;
  assign bus.dmemstore = store_q;
  assign bus.halt      = halt_q;
  assign bus.busy      = busy_q;
  assign bus.dhit      = dhit_q;
  assign bus.ihit      = bus.ihit_raw & imem_ren_q;

`ifdef MEM_REQUEST_PERF_EN
  logic [PERF_W-1:0] dstall_cnt;
  logic [PERF_W-1:0] dacc_cnt;

  mem_request_perf #(
    .CNT_W(PERF_W)
  ) u_perf (
    .CLK        (CLK),
    .nRST       (nRST),
    .in_dreq    (state == DREQ),
    .dhit       (dhit_q),
    .halt       (halt_q),
    .dstall_cnt (dstall_cnt),
    .dacc_cnt   (dacc_cnt)
  );

  assign bus.perf_dstall_cnt = dstall_cnt;
  assign bus.perf_dacc_cnt   = dacc_cnt;
`else
  assign bus.perf_dstall_cnt = '0;
  assign bus.perf_dacc_cnt   = '0;
`endif

endmodule

// File: tb/tb_mem_request_unit.sv
// Self-checking bench for mem_request_unit: access table, halt, masking, flush and reset corner cases.
module tb_mem_request_unit;
  import cpu_types_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  mem_request_unit_if #(.ADDR_W(32)) bus ();

  mem_request_unit #(.ADDR_W(32)) dut (
    .CLK  (clk),
    .nRST (rst_n),
    .bus  (bus)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  typedef struct {
    logic  ren;
    logic  wen;
    word_t addr;
    word_t data;
  } req_t;

  typedef struct {
    logic        ren;
    logic        wen;
    word_t       addr;
    word_t       data;
    int unsigned lat;
    logic        adv;
    logic        exp_ren;
    logic        exp_wen;
  } vec_t;

  req_t sb_q[$];
  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_dREN    = 1'b0;
    bus.mem_dWEN    = 1'b0;
    bus.mem_halt    = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_store   = '0;
    bus.mem_advance = 1'b0;
    bus.mem_flush   = 1'b0;
    bus.ihit_raw    = 1'b0;
    bus.dhit_raw    = 1'b0;
  endtask

  task automatic sb_check(input string tag);
    req_t got;
    if (sb_q.size() == 0) begin
      chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    end else begin
      got = sb_q.pop_front();
      chk({tag, "_dmemREN"},   bus.dmemREN,   got.ren);
      chk({tag, "_dmemWEN"},   bus.dmemWEN,   got.wen);
      chk({tag, "_dmemaddr"},  bus.dmemaddr,  got.addr);
      chk({tag, "_dmemstore"}, bus.dmemstore, got.data);
    end
  endtask

  // Drive one MEM-stage access, hold it for lat DREQ cycles, then complete it.
  task automatic do_access(input logic ren, input logic wen, input word_t addr, input word_t data,
                           input int unsigned lat, input logic adv,
                           input logic exp_ren, input logic exp_wen);
    bus.mem_dREN  = ren;
    bus.mem_dWEN  = wen;
    bus.mem_addr  = addr;
    bus.mem_store = data;
    sb_q.push_back('{exp_ren, exp_wen, addr, data});
    tick();
    sb_check("accept");
    chk("accept_busy", bus.busy, 1'b1);
    for (int unsigned c = 1; c <= lat; c++) begin
      chk("hold_dmemREN", bus.dmemREN, exp_ren);
      chk("hold_dmemWEN", bus.dmemWEN, exp_wen);
      chk("hold_imemREN", bus.imemREN, 1'b0);
      if (c == lat) begin
        bus.dhit_raw    = 1'b1;
        bus.mem_advance = adv;
      end
      #1;
      chk("dhit_pulse", bus.dhit, (c == lat));
      tick();
    end
    bus.dhit_raw    = 1'b0;
    bus.mem_advance = 1'b0;
    if (adv) begin
      bus.mem_dREN = 1'b0;
      bus.mem_dWEN = 1'b0;
    end
    chk("done_dmemREN", bus.dmemREN, 1'b0);
    chk("done_dmemWEN", bus.dmemWEN, 1'b0);
    chk("done_busy",    bus.busy,    1'b0);
    chk("done_imemREN", bus.imemREN, 1'b1);
    chk("done_dhit",    bus.dhit,    1'b0);
    if (!adv) begin
      repeat (2) begin
        tick();
        chk("noreissue_dmemREN", bus.dmemREN, 1'b0);
        chk("noreissue_dmemWEN", bus.dmemWEN, 1'b0);
        chk("noreissue_busy",    bus.busy,    1'b0);
      end
      bus.mem_advance = 1'b1;
      bus.mem_dREN    = 1'b0;
      bus.mem_dWEN    = 1'b0;
      tick();
      bus.mem_advance = 1'b0;
    end
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_imemREN",   bus.imemREN,   1'b1);
    chk("rst_dmemREN",   bus.dmemREN,   1'b0);
    chk("rst_dmemWEN",   bus.dmemWEN,   1'b0);
    chk("rst_halt",      bus.halt,      1'b0);
    chk("rst_busy",      bus.busy,      1'b0);
    chk("rst_dmemaddr",  bus.dmemaddr,  32'h0);
    chk("rst_dmemstore", bus.dmemstore, 32'h0);
    chk("rst_perf_dstall", bus.perf_dstall_cnt, 32'h0);
    chk("rst_perf_dacc",   bus.perf_dacc_cnt,   32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0000_0000, 3, 1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 1, 1'b0, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 32'h0000_03FC, 32'h1234_5678, 2, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0000, 1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      do_access(vecs[i].ren, vecs[i].wen, vecs[i].addr, vecs[i].data,
                vecs[i].lat, vecs[i].adv, vecs[i].exp_ren, vecs[i].exp_wen);
    end

    // Spurious data hit in IDLE is masked; instruction hit passes while fetching.
    bus.dhit_raw = 1'b1;
    bus.ihit_raw = 1'b1;
    #1;
    chk("idle_dhit_masked", bus.dhit, 1'b0);
    chk("idle_ihit_pass",   bus.ihit, 1'b1);
    idle_inputs();
    tick();

    // Flushed request and flushed halt are both ignored.
    bus.mem_dREN = 1'b1;
    bus.mem_addr = 32'h0000_0999;
    bus.mem_flush = 1'b1;
    tick();
    chk("flush_dmemREN",  bus.dmemREN,  1'b0);
    chk("flush_busy",     bus.busy,     1'b0);
    chk("flush_dmemaddr", bus.dmemaddr, 32'hFFFF_FFFC);
    bus.mem_dREN = 1'b0;
    bus.mem_halt = 1'b1;
    tick();
    chk("flush_halt",    bus.halt,    1'b0);
    chk("flush_imemREN", bus.imemREN, 1'b1);
    idle_inputs();
    tick();

    // Halt while a load is outstanding: the load completes, then HALTED.
    bus.mem_dREN = 1'b1;
    bus.mem_addr = 32'h0000_0040;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_0040, 32'h0});
    tick();
    sb_check("hload");
    bus.mem_halt  = 1'b1;
    bus.mem_flush = 1'b1;
    tick();
    chk("hload_busy",    bus.busy,    1'b1);
    chk("hload_dmemREN", bus.dmemREN, 1'b1);
    chk("hload_halt",    bus.halt,    1'b0);
    bus.mem_flush   = 1'b0;
    bus.dhit_raw    = 1'b1;
    bus.mem_advance = 1'b1;
    #1;
    chk("hload_dhit", bus.dhit, 1'b1);
    tick();
    bus.dhit_raw    = 1'b0;
    bus.mem_advance = 1'b0;
    bus.mem_dREN    = 1'b0;
    chk("hload_done_halt", bus.halt,    1'b0);
    chk("hload_done_busy", bus.busy,    1'b0);
    tick();
    chk("halted_halt",    bus.halt,    1'b1);
    chk("halted_imemREN", bus.imemREN, 1'b0);
    for (int i = 0; i < 12; i++) begin
      bus.ihit_raw    = 1'b1;
      bus.dhit_raw    = i[0];
      bus.mem_dREN    = 1'($urandom_range(0, 1));
      bus.mem_dWEN    = 1'($urandom_range(0, 1));
      bus.mem_advance = 1'($urandom_range(0, 1));
      bus.mem_flush   = 1'($urandom_range(0, 1));
      #1;
      chk("halted_sticky",  bus.halt,    1'b1);
      chk("halted_imem",    bus.imemREN, 1'b0);
      chk("halted_ihit",    bus.ihit,    1'b0);
      chk("halted_dhit",    bus.dhit,    1'b0);
      chk("halted_dmemREN", bus.dmemREN, 1'b0);
      chk("halted_dmemWEN", bus.dmemWEN, 1'b0);
      tick();
    end
    idle_inputs();

    // Reset mid-DREQ drops the request at once; the same request is re-accepted after release.
    rst_n = 1'b0;
    #1;
    chk("rst2_halt", bus.halt, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    bus.mem_dREN = 1'b1;
    bus.mem_addr = 32'h0000_0080;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_0080, 32'h0});
    tick();
    sb_check("pre_rst");
    #2 rst_n = 1'b0;
    bus.dhit_raw = 1'b1;
    #1;
    chk("midrst_dmemREN", bus.dmemREN, 1'b0);
    chk("midrst_imemREN", bus.imemREN, 1'b1);
    chk("midrst_busy",    bus.busy,    1'b0);
    chk("midrst_dhit",    bus.dhit,    1'b0);
    bus.dhit_raw = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    sb_q.push_back('{1'b1, 1'b0, 32'h0000_0080, 32'h0});
    tick();
    sb_check("reaccept");
    chk("reaccept_busy", bus.busy, 1'b1);
    bus.dhit_raw    = 1'b1;
    bus.mem_advance = 1'b1;
    tick();
    idle_inputs();
    tick();

`ifdef MEM_REQUEST_PERF_EN
    rst_n = 1'b0;
    #1;
    @(negedge clk) rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      do_access(1'b1, 1'b0, 32'h0000_1000 + 32'(i * 4), 32'h0, 3, 1'b1, 1'b1, 1'b0);
    end
    chk("perf_dacc",   bus.perf_dacc_cnt,   32'd4);
    chk("perf_dstall", bus.perf_dstall_cnt, 32'd12);
`else
    chk("perf_off_dacc",   bus.perf_dacc_cnt,   32'd0);
    chk("perf_off_dstall", bus.perf_dstall_cnt, 32'd0);
`endif

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
